// File: rtl/seq_bit_serializer_if.sv
// Word-input handshake bundle for seq_bit_serializer.
// A word transfers on a rising edge where in_valid and in_ready are both high;
// in_ready depends on registers only, so it never combinationally waits on in_valid.
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);
  localparam int LW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] in_data;
  logic [LW-1:0]    in_len;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_len, output in_valid, input in_ready);
  modport slave  (input in_data, input in_len, input in_valid, output in_ready);
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial bit source: MSB-first, one bit per clock, with a one-word
// holding register so consecutive words stream with no idle bit between them.
module seq_bit_serializer #(
  parameter int WIDTH = 8,
  localparam int LW = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_bit_serializer_if.slave   in_if,
  output logic                  x,
  output logic                  x_valid,
  output logic                  word_done,
  output logic                  busy
);

  localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  logic [WIDTH-1:0] sh;
  logic [LW-1:0]    cnt;
  logic [WIDTH-1:0] hd_data;
  logic [LW-1:0]    hd_len;
  logic             hd_full;

  logic [LW-1:0]    len_eff;
  logic [LW-1:0]    shamt;
  logic [WIDTH-1:0] load_data;
  logic             len_zero;
  logic             cnt_le1;
  logic             accept;

  // Left-align the valid field; the WIDTH-wide shift drops any bits above len.
  always_comb begin
    len_eff   = (in_if.in_len > WIDTH_L) ? WIDTH_L : in_if.in_len;
    shamt     = WIDTH_L - len_eff;
    load_data = in_if.in_data << shamt;
    len_zero  = (len_eff == '0);
    cnt_le1   = (cnt <= ONE_L);
  end

  assign in_if.in_ready = !hd_full;
  assign accept         = in_if.in_valid & !hd_full;

  assign x         = sh[WIDTH-1];
  assign x_valid   = (cnt != '0);
  assign word_done = (cnt == ONE_L);
  assign busy      = x_valid | hd_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh      <= '0;
      cnt     <= '0;
      hd_data <= '0;
      hd_len  <= '0;
      hd_full <= 1'b0;
    end else if (cnt_le1 && hd_full) begin
      // Held word takes over right as the last bit leaves: zero-gap streaming.
      sh      <= hd_data;
      cnt     <= hd_len;
      hd_data <= '0;
      hd_len  <= '0;
      hd_full <= 1'b0;
    end else if (cnt_le1 && accept && !len_zero) begin
      sh  <= load_data;
      cnt <= len_eff;
    end else begin
      if (cnt != '0) begin
        sh  <= sh << 1;
        cnt <= cnt - ONE_L;
      end
      // Reaching here with a non-empty accepted word implies cnt > 1.
      if (accept && !len_zero) begin
        hd_data <= load_data;
        hd_len  <= len_eff;
        hd_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: reset, single word, streaming,
// length edges, backpressure and asynchronous reset mid-word.
module tb_seq_bit_serializer;

  localparam int WIDTH = 8;
  localparam int LW    = $clog2(WIDTH + 1);

  logic clk;
  logic rst_n;
  logic x;
  logic x_valid;
  logic word_done;
  logic busy;

  seq_bit_serializer_if #(.WIDTH(WIDTH)) bus ();

  seq_bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_if     (bus),
    .x         (x),
    .x_valid   (x_valid),
    .word_done (word_done),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [LW-1:0] l);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_len   = l;
  endtask

  task automatic push_bits(input logic [WIDTH-1:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(d[i]);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_x"}, {31'd0, x}, 0);
    check({tag, "_xv"}, {31'd0, x_valid}, 0);
    check({tag, "_wd"}, {31'd0, word_done}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  // Compare one observed cycle against the expected-bit queue.
  task automatic check_stream(input string tag, input int c, input int nbits,
                              input logic wd_exp, input logic rdy_exp);
    logic [0:0] b;
    if (c <= nbits) begin
      b = exp_q.pop_front();
      check({tag, "_xv"}, {31'd0, x_valid}, 1);
      check({tag, "_x"}, {31'd0, x}, {31'd0, b});
    end else begin
      check({tag, "_xv_idle"}, {31'd0, x_valid}, 0);
      check({tag, "_x_idle"}, {31'd0, x}, 0);
    end
    check({tag, "_wd"}, {31'd0, word_done}, {31'd0, wd_exp});
    check({tag, "_rdy"}, {31'd0, bus.in_ready}, {31'd0, rdy_exp});
  endtask

  logic [3:0] win;
  int hits;

  initial begin
    // reset with in_valid high
    rst_n = 1'b0;
    drive(1'b1, 8'hFF, 4'd8);
    repeat (3) begin
      @(negedge clk);
      check_idle("rst");
      check("rst_rdy", {31'd0, bus.in_ready}, 1);
    end
    drive(1'b0, 8'h00, 4'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("post_rst");
    end

    // single word 0B / len 4 -> 1,0,1,1
    drive(1'b1, 8'h0B, 4'd4);
    push_bits(8'h0B, 4);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) drive(1'b0, 8'h00, 4'd0);
      check_stream("single", c, 4, c == 4, 1'b1);
    end

    // streaming A5/8 then 0A/4, zero gap across the boundary
    drive(1'b1, 8'hA5, 4'd8);
    push_bits(8'hA5, 8);
    push_bits(8'h0A, 4);
    win = '0;
    hits = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (x_valid) begin
        win = {win[2:0], x};
        if (win == 4'b1010) hits++;
      end
      check_stream("stream", c, 12, (c == 8) || (c == 12), !(c >= 2 && c <= 8));
      if (c == 1) drive(1'b1, 8'h0A, 4'd4);
      if (c == 2) drive(1'b0, 8'h00, 4'd0);
    end
    check("stream_1010_hits", hits, 2);
    check("stream_q_empty", exp_q.size(), 0);

    // len 0: accepted and dropped
    drive(1'b1, 8'hFF, 4'd0);
    check("len0_rdy", {31'd0, bus.in_ready}, 1);
    repeat (3) begin
      @(negedge clk);
      drive(1'b0, 8'h00, 4'd0);
      check_idle("len0");
    end

    // len 9 clamps to 8
    drive(1'b1, 8'hFF, 4'd9);
    push_bits(8'hFF, 8);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) drive(1'b0, 8'h00, 4'd0);
      check_stream("len9", c, 8, c == 8, 1'b1);
    end

    // backpressure: toggled data while hold is full must not leak
    drive(1'b1, 8'hC3, 4'd8);
    push_bits(8'hC3, 8);
    push_bits(8'h09, 4);
    push_bits(8'h06, 4);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      check_stream("bp", c, 16, (c == 8) || (c == 12) || (c == 16),
                   !((c >= 2 && c <= 8) || (c >= 10 && c <= 12)));
      if (c == 1) drive(1'b1, 8'h09, 4'd4);
      else if (c >= 2 && c <= 8) drive(1'b1, (c % 2 == 0) ? 8'h0E : 8'h01, 4'd4);
      else if (c == 9) drive(1'b1, 8'h06, 4'd4);
      else if (c == 10) drive(1'b0, 8'h00, 4'd0);
    end
    check("bp_q_empty", exp_q.size(), 0);

    // async reset mid-word with a held word present
    drive(1'b1, 8'hFF, 4'd8);
    @(negedge clk);
    drive(1'b1, 8'h0F, 4'd4);
    @(negedge clk);
    drive(1'b0, 8'h00, 4'd0);
    check("mid_xv_pre", {31'd0, x_valid}, 1);
    check("mid_busy_pre", {31'd0, busy}, 1);
    check("mid_rdy_pre", {31'd0, bus.in_ready}, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_idle("mid_async");
    check("mid_async_rdy", {31'd0, bus.in_ready}, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check_idle("mid_after");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
